dpram_pingpong_writer: RTL and testbench

//  Upstream feeder for the DPRAM port A write side. Accepts a stream of audio samples over a

---
 rtl/dpram_pingpong_writer_pkg.sv | 18 +
 rtl/dpram_pingpong_writer_if.sv | 36 +++
 rtl/dpram_pingpong_writer_tracker.sv | 52 +++++
 rtl/dpram_pingpong_writer.sv | 90 +++++++++
 tb/tb_dpram_pingpong_writer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pingpong_writer_pkg.sv
// Shared definitions for the DPRAM ping-pong writer slice.
//  - default widths of the DPRAM port A address/data and of the overflow counter
//  - frame_len(): words per ping-pong bank for a given address width
//  - bank_idx_t: index of one of the two banks (the address MSB)
package dpram_buf_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_OVF_WIDTH  = 16;

    typedef logic bank_idx_t;

    // Each bank is half of the port A address space.
    function automatic int frame_len(input int addr_width);
        return 1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/dpram_pingpong_writer_if.sv
// Bus bundle between the sample source / DPRAM / frame consumer and the writer.
//  s_valid, s_data   sample offered by the upstream source
//  s_ready           writer can take a sample this cycle
//  a_addr, a_wr_data, a_wr_en   DPRAM port A write port (registered in the writer)
//  frame_vld, frame_bank        complete frame available and the bank holding it
//  frame_done        consumer release pulse for frame_bank
//  ovf_cnt           saturating count of samples offered while not ready
// The master modport is the environment side, the slave modport is the writer.
interface dpram_pingpong_writer_if
    import dpram_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVF_WIDTH  = DEF_OVF_WIDTH
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wr_data;
    logic                  a_wr_en;
    logic                  frame_vld;
    bank_idx_t             frame_bank;
    logic                  frame_done;
    logic [OVF_WIDTH-1:0]  ovf_cnt;

    modport master (
        output s_valid, s_data, frame_done,
        input  s_ready, a_addr, a_wr_data, a_wr_en, frame_vld, frame_bank, ovf_cnt
    );

    modport slave (
        input  s_valid, s_data, frame_done,
        output s_ready, a_addr, a_wr_data, a_wr_en, frame_vld, frame_bank, ovf_cnt
    );
endinterface

// File: rtl/dpram_pingpong_writer_tracker.sv
// Ping-pong bank ownership tracker.
//  a_clk, tb_a_rst   clock / asynchronous active-high reset
//  clr               synchronous clear of all bank state (highest priority)
//  frame_end         the writer issues the final word of wr_bank this edge
//  frame_done        consumer releases frame_bank (ignored unless frame_vld)
//  wr_bank           bank the writer fills next
//  frame_bank        bank the consumer reads
//  wr_full           wr_bank still holds an unreleased frame (writer must stall)
//  frame_vld         frame_bank holds a complete frame
module dpram_bank_tracker
    import dpram_buf_pkg::*;
(
    input  logic      a_clk,
    input  logic      tb_a_rst,
    input  logic      clr,
    input  logic      frame_end,
    input  logic      frame_done,
    output bank_idx_t wr_bank,
    output bank_idx_t frame_bank,
    output logic      wr_full,
    output logic      frame_vld
);

    logic [1:0] bank_full;

    assign wr_full   = bank_full[wr_bank];
    assign frame_vld = bank_full[frame_bank];

    // A frame end can only happen on a non-full bank and a release only on a full one,
    // so when both fire together they touch different bits of bank_full.
    always_ff @(posedge a_clk or posedge tb_a_rst) begin
        if (tb_a_rst) begin
            bank_full  <= 2'b00;
            wr_bank    <= 1'b0;
            frame_bank <= 1'b0;
        end else if (clr) begin
            bank_full  <= 2'b00;
            wr_bank    <= 1'b0;
            frame_bank <= 1'b0;
        end else begin
            if (frame_end) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
            end
            if (frame_done && frame_vld) begin
                bank_full[frame_bank] <= 1'b0;
                frame_bank            <= ~frame_bank;
            end
        end
    end

endmodule

// File: rtl/dpram_pingpong_writer.sv
// Streams audio samples into DPRAM port A as two ping-pong frames.
//  a_clk     DPRAM port A clock, all logic on its rising edge
//  tb_a_rst  asynchronous active-high reset
//  clr       synchronous clear of frame state, write enable and overflow count
//  bus       slave side of dpram_pingpong_writer_if (sample handshake, port A
//            write port, frame announce/release, overflow count)
// Each accepted sample is written one cycle later at {wr_bank, idx}. Samples offered
// while both banks are full are dropped and counted in a saturating counter.
module dpram_pingpong_writer
    import dpram_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVF_WIDTH  = DEF_OVF_WIDTH
)(
    input  logic                     a_clk,
    input  logic                     tb_a_rst,
    input  logic                     clr,
    dpram_pingpong_writer_if.slave   bus
);

    localparam int IDX_W     = ADDR_WIDTH - 1;
    localparam int FRAME_LEN = frame_len(ADDR_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wr_data;
    logic                  a_wr_en;
    logic [OVF_WIDTH-1:0]  ovf_cnt;
    bank_idx_t             wr_bank;
    bank_idx_t             frame_bank;
    logic                  wr_full;
    logic                  frame_vld;
    logic                  s_ready;
    logic                  accept;
    logic                  frame_end;

    // Ready depends only on registered state and clr, never on s_valid.
    assign s_ready   = !clr && !wr_full;
    assign accept    = bus.s_valid && s_ready;
    assign frame_end = accept && (idx == LAST_IDX);

    dpram_bank_tracker u_tracker (
        .a_clk      (a_clk),
        .tb_a_rst   (tb_a_rst),
        .clr        (clr),
        .frame_end  (frame_end),
        .frame_done (bus.frame_done),
        .wr_bank    (wr_bank),
        .frame_bank (frame_bank),
        .wr_full    (wr_full),
        .frame_vld  (frame_vld)
    );

    // idx wraps to zero on its own after the last word of a bank, which is exactly
    // the frame-end restart; the tracker flips wr_bank on the same edge.
    always_ff @(posedge a_clk or posedge tb_a_rst) begin
        if (tb_a_rst) begin
            idx       <= '0;
            a_addr    <= '0;
            a_wr_data <= '0;
            a_wr_en   <= 1'b0;
            ovf_cnt   <= '0;
        end else if (clr) begin
            idx       <= '0;
            a_wr_en   <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            a_wr_en <= accept;
            if (accept) begin
                a_addr    <= {wr_bank, idx};
                a_wr_data <= bus.s_data;
                idx       <= idx + 1'b1;
            end
            if (bus.s_valid && !s_ready && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.a_addr     = a_addr;
    assign bus.a_wr_data  = a_wr_data;
    assign bus.a_wr_en    = a_wr_en;
    assign bus.frame_vld  = frame_vld;
    assign bus.frame_bank = frame_bank;
    assign bus.ovf_cnt    = ovf_cnt;

endmodule

// File: tb/tb_dpram_pingpong_writer.sv
// Testbench for dpram_pingpong_writer (ADDR_WIDTH=10, DATA_WIDTH=18, OVF_WIDTH=16).
// The driver issues directed stimulus one cycle at a time and pushes each expected
// port A write (with the cycle it must appear on) into a queue; an independent
// monitor pops and compares whenever a write is due, and flags unexpected writes.
module tb_dpram_pingpong_writer;
    import dpram_buf_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int OW    = 16;
    localparam int DEPTH = 1024;

    logic a_clk    = 1'b0;
    logic tb_a_rst = 1'b1;
    logic clr      = 1'b0;

    dpram_pingpong_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OVF_WIDTH(OW)) bus ();

    dpram_pingpong_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OVF_WIDTH(OW)) dut (
        .a_clk    (a_clk),
        .tb_a_rst (tb_a_rst),
        .clr      (clr),
        .bus      (bus)
    );

    always #5 a_clk = ~a_clk;

    typedef struct {
        int unsigned   due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            sample_k = 0;
    logic [DW-1:0] port_b_mem [DEPTH];
    logic [DW-1:0] exp_mem    [DEPTH];

    // Reference state of the frame bookkeeping.
    logic [1:0]    m_full;
    logic          m_wb;
    logic          m_fb;
    logic [AW-2:0] m_idx;
    logic [OW-1:0] m_ovf;

    always @(posedge a_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: captures port A writes into a port-B-side memory image and checks them.
    always @(negedge a_clk) begin
        if (!tb_a_rst) begin
            if (bus.a_wr_en === 1'b1) port_b_mem[bus.a_addr] = bus.a_wr_data;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("a_wr_en", 32'(bus.a_wr_en), 32'd1);
                check("a_addr", 32'(bus.a_addr), 32'(exp_q[0].addr));
                check("a_wr_data", 32'(bus.a_wr_data), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                check("a_wr_en idle", 32'(bus.a_wr_en), 32'd0);
            end
        end
    end

    task automatic model_reset();
        m_full = 2'b00;
        m_wb   = 1'b0;
        m_fb   = 1'b0;
        m_idx  = '0;
        m_ovf  = '0;
    endtask

    task automatic checkOutput(input logic c);
        check("s_ready", 32'(bus.s_ready), 32'(!c && !m_full[m_wb]));
        check("frame_vld", 32'(bus.frame_vld), 32'(m_full[m_fb]));
        check("frame_bank", 32'(bus.frame_bank), 32'(m_fb));
        check("ovf_cnt", 32'(bus.ovf_cnt), 32'(m_ovf));
    endtask

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic done, input logic c);
        logic rdy, acc, done_eff, old_fb;
        bus.s_valid    = v;
        bus.s_data     = d;
        bus.frame_done = done;
        clr            = c;
        @(negedge a_clk);
        checkOutput(c);
        rdy      = !c && !m_full[m_wb];
        acc      = v && rdy;
        done_eff = done && m_full[m_fb];
        old_fb   = m_fb;
        if (c) begin
            model_reset();
        end else begin
            if (acc) begin
                exp_q.push_back('{due: cyc + 1, addr: {m_wb, m_idx}, data: d});
                exp_mem[{m_wb, m_idx}] = d;
                if (m_idx == 9'd511) begin
                    m_full[m_wb] = 1'b1;
                    m_wb         = ~m_wb;
                end
                m_idx = m_idx + 1'b1;
            end
            if (v && !rdy && m_ovf != 16'hFFFF) m_ovf = m_ovf + 1'b1;
            if (done_eff) begin
                m_full[old_fb] = 1'b0;
                m_fb           = ~old_fb;
            end
        end
        @(posedge a_clk);
        #1;
    endtask

    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 18'h3FFFF - DW'(sample_k), 1'b0, 1'b0);
            sample_k++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Asserts reset between clock edges, in the middle of whatever frame is open.
    task automatic doReset();
        bus.s_valid    = 1'b0;
        bus.frame_done = 1'b0;
        clr            = 1'b0;
        @(negedge a_clk);
        #2;
        tb_a_rst = 1'b1;
        exp_q.delete();
        model_reset();
        @(posedge a_clk);
        @(posedge a_clk);
        #1;
        tb_a_rst = 1'b0;
    endtask

    initial begin
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.frame_done = 1'b0;
        model_reset();
        repeat (3) @(posedge a_clk);
        #1;
        tb_a_rst = 1'b0;

        // 1: reset state
        check("rst a_addr", 32'(bus.a_addr), 32'd0);
        check("rst a_wr_data", 32'(bus.a_wr_data), 32'd0);
        check("rst a_wr_en", 32'(bus.a_wr_en), 32'd0);
        check("rst s_ready", 32'(bus.s_ready), 32'd1);
        check("rst frame_vld", 32'(bus.frame_vld), 32'd0);
        idle(2);

        // 2: first frame, data 0x3FFFF downcounting
        send_samples(512);
        check("t2 last addr", 32'(bus.a_addr), 32'd511);
        check("t2 last data", 32'(bus.a_wr_data), 32'h3FE00);
        check("t2 frame_vld", 32'(bus.frame_vld), 32'd1);
        check("t2 frame_bank", 32'(bus.frame_bank), 32'd0);
        send_samples(1);
        check("t2 sample512 addr", 32'(bus.a_addr), 32'd512);

        // 3: fill both banks, then overflow for 7 cycles and read the image back
        send_samples(511);
        check("t3 s_ready", 32'(bus.s_ready), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 18'h12345, 1'b0, 1'b0);
        check("t3 ovf_cnt", 32'(bus.ovf_cnt), 32'd7);
        idle(1);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t3 readback[%0d]", i), 32'(port_b_mem[i]), 32'(exp_mem[i]));
        end

        // 4: release bank 0 on the same edge as the final bank-1 write
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        check("t4 clr ovf_cnt", 32'(bus.ovf_cnt), 32'd0);
        check("t4 clr frame_vld", 32'(bus.frame_vld), 32'd0);
        send_samples(1023);
        applyStimulus(1'b1, 18'h0ABCD, 1'b1, 1'b0);
        check("t4 frame_bank", 32'(bus.frame_bank), 32'd1);
        check("t4 frame_vld", 32'(bus.frame_vld), 32'd1);
        check("t4 s_ready", 32'(bus.s_ready), 32'd1);
        check("t4 final addr", 32'(bus.a_addr), 32'd1023);
        send_samples(1);
        check("t4 wrap addr", 32'(bus.a_addr), 32'd0);

        // 5: clr mid-frame, then reset mid-frame
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        send_samples(300);
        applyStimulus(1'b1, 18'h1FFFF, 1'b0, 1'b1);
        check("t5 clr a_wr_en", 32'(bus.a_wr_en), 32'd0);
        check("t5 clr frame_vld", 32'(bus.frame_vld), 32'd0);
        check("t5 clr hold addr", 32'(bus.a_addr), 32'd299);
        send_samples(1);
        check("t5 clr next addr", 32'(bus.a_addr), 32'd0);
        send_samples(300);
        doReset();
        check("t5 rst a_addr", 32'(bus.a_addr), 32'd0);
        check("t5 rst a_wr_en", 32'(bus.a_wr_en), 32'd0);
        check("t5 rst ovf_cnt", 32'(bus.ovf_cnt), 32'd0);
        check("t5 rst frame_vld", 32'(bus.frame_vld), 32'd0);
        send_samples(2);
        check("t5 rst next addr", 32'(bus.a_addr), 32'd1);

        // 6: ignored release, then overflow saturation
        doReset();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        check("t6 frame_bank", 32'(bus.frame_bank), 32'd0);
        check("t6 frame_vld", 32'(bus.frame_vld), 32'd0);
        check("t6 s_ready", 32'(bus.s_ready), 32'd1);
        send_samples(1024);
        for (int i = 0; i < 65540; i++) applyStimulus(1'b1, 18'h00F0F, 1'b0, 1'b0);
        check("t6 ovf_cnt sat", 32'(bus.ovf_cnt), 32'hFFFF);

        idle(3);
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
